// File: rtl/tape_ctrl.sv
// One-cell write-back cache between a tape-machine datapath and tape memory.
// The head cell is held locally; a head move triggers write-back (if dirty) then fetch.
module tape_ctrl #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] head_ptr,
    input  logic              cell_write,
    input  logic [DATA_W-1:0] cell_wdata,
    output logic [DATA_W-1:0] cell_data,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        ST_VALID = 2'd0,
        ST_WB    = 2'd1,
        ST_FETCH = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cached_addr;
    logic [ADDR_W-1:0] cached_addr_next;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] fetch_addr_next;
    logic [DATA_W-1:0] cell_data_next;
    logic              dirty;
    logic              dirty_next;
    logic              miss;

    // State and cache registers; reset restarts with a fetch of cell 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_FETCH;
            fetch_addr  <= '0;
            cached_addr <= '0;
            cell_data   <= '0;
            dirty       <= 1'b0;
        end else begin
            state       <= state_next;
            fetch_addr  <= fetch_addr_next;
            cached_addr <= cached_addr_next;
            cell_data   <= cell_data_next;
            dirty       <= dirty_next;
        end
    end

    // Next-state, cache update and memory request decode.
    always_comb begin
        state_next       = state;
        fetch_addr_next  = fetch_addr;
        cached_addr_next = cached_addr;
        cell_data_next   = cell_data;
        dirty_next       = dirty;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = cached_addr;
        mem_wdata        = cell_data;
        miss             = (state == ST_VALID) && (head_ptr != cached_addr);

        unique case (state)
            ST_VALID: begin
                if (miss) begin
                    // A write racing a miss is dropped; the pointer is already elsewhere.
                    fetch_addr_next = head_ptr;
                    state_next      = dirty ? ST_WB : ST_FETCH;
                end else if (cell_write) begin
                    cell_data_next = cell_wdata;
                    dirty_next     = 1'b1;
                end
            end
            ST_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cached_addr;
                mem_wdata = cell_data;
                if (mem_ack) begin
                    dirty_next = 1'b0;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = fetch_addr;
                if (mem_ack) begin
                    cell_data_next   = mem_rdata;
                    cached_addr_next = fetch_addr;
                    state_next       = ST_VALID;
                end
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase

        stall = (state != ST_VALID) || miss;
    end

endmodule
